// File: rtl/ddr3_app_responder.sv
// BRAM-backed stand-in for the DDR3 user interface: calibration delay, in-order
// command execution with write-data pairing, fixed read latency and refresh stalls.
module ddr3_app_responder #(
    parameter int DATA_W       = 256,
    parameter int ADDR_W       = 29,
    parameter int MEM_AW       = 10,
    parameter int CMD_DEPTH    = 4,
    parameter int WDF_DEPTH    = 4,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 64,
    parameter int REF_PERIOD   = 512,
    parameter int REF_CYCLES   = 8
) (
    input  logic                ui_clk,
    input  logic                ui_clk_sync_rst,
    input  logic [2:0]          cmd,
    input  logic                cmd_en,
    input  logic [ADDR_W-1:0]   addr,
    output logic                cmd_ready,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_data_en,
    input  logic                wr_data_end,
    input  logic [DATA_W/8-1:0] wr_data_mask,
    output logic                wr_data_rdy,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_data_valid,
    output logic                rd_data_end,
    output logic                init_calib_complete,
    output logic                err
);
    localparam int NB    = DATA_W / 8;
    localparam int CQ_AW = $clog2(CMD_DEPTH);
    localparam int WQ_AW = $clog2(WDF_DEPTH);
    localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    logic [CAL_W-1:0] cal_cnt_reg;
    logic             calib_reg;
    logic             refresh_active;

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            cal_cnt_reg <= '0;
            calib_reg   <= 1'b0;
        end else if (!calib_reg) begin
            if (cal_cnt_reg == CAL_W'(CALIB_CYCLES - 1))
                calib_reg <= 1'b1;
            else
                cal_cnt_reg <= cal_cnt_reg + CAL_W'(1);
        end
    end

    // Refresh window occupies the last REF_CYCLES counts of every period.
    generate
        if (REF_PERIOD > 0) begin : g_refresh
            localparam int REF_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
            localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REF_PERIOD - 1);
            localparam logic [REF_W-1:0] REF_START = REF_W'(REF_PERIOD - REF_CYCLES);
            logic [REF_W-1:0] ref_cnt_reg;

            always_ff @(posedge ui_clk) begin
                if (ui_clk_sync_rst)
                    ref_cnt_reg <= '0;
                else if (calib_reg)
                    ref_cnt_reg <= (ref_cnt_reg == REF_LAST) ? '0 : ref_cnt_reg + REF_W'(1);
            end
            assign refresh_active = calib_reg && (REF_CYCLES > 0) && (ref_cnt_reg >= REF_START);
        end else begin : g_no_refresh
            assign refresh_active = 1'b0;
        end
    endgenerate

    logic [MEM_AW+2:0]    cmdq_mem [CMD_DEPTH];
    logic [CQ_AW:0]       cq_wr_ptr_reg, cq_rd_ptr_reg;
    logic [DATA_W+NB-1:0] wdfq_mem [WDF_DEPTH];
    logic [WQ_AW:0]       wq_wr_ptr_reg, wq_rd_ptr_reg;
    logic                 cmdq_full, cmdq_empty, wdfq_full, wdfq_empty;
    logic                 cmd_push, cmd_pop, wdf_push, wdf_pop;
    logic                 exec_read, exec_write;
    logic [2:0]           head_cmd;
    logic [MEM_AW-1:0]    head_idx;
    logic [DATA_W-1:0]    wdf_data;
    logic [NB-1:0]        wdf_mask;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{addr[ADDR_W-1:MEM_AW+3], addr[2:0]};

    assign cmdq_empty = (cq_wr_ptr_reg == cq_rd_ptr_reg);
    assign cmdq_full  = (cq_wr_ptr_reg[CQ_AW] != cq_rd_ptr_reg[CQ_AW]) &&
                        (cq_wr_ptr_reg[CQ_AW-1:0] == cq_rd_ptr_reg[CQ_AW-1:0]);
    assign wdfq_empty = (wq_wr_ptr_reg == wq_rd_ptr_reg);
    assign wdfq_full  = (wq_wr_ptr_reg[WQ_AW] != wq_rd_ptr_reg[WQ_AW]) &&
                        (wq_wr_ptr_reg[WQ_AW-1:0] == wq_rd_ptr_reg[WQ_AW-1:0]);

    assign cmd_ready   = calib_reg && !cmdq_full && !refresh_active;
    assign wr_data_rdy = calib_reg && !wdfq_full;
    assign cmd_push    = cmd_en && cmd_ready;
    assign wdf_push    = wr_data_en && wr_data_rdy;

    assign {head_cmd, head_idx} = cmdq_mem[cq_rd_ptr_reg[CQ_AW-1:0]];
    assign {wdf_mask, wdf_data} = wdfq_mem[wq_rd_ptr_reg[WQ_AW-1:0]];

    // A write head without data blocks the queue; illegal codes just drain.
    assign exec_read  = !cmdq_empty && (head_cmd == CMD_RD);
    assign exec_write = !cmdq_empty && (head_cmd == CMD_WR) && !wdfq_empty;
    assign cmd_pop    = !cmdq_empty && ((head_cmd != CMD_WR) || !wdfq_empty);
    assign wdf_pop    = exec_write;

    always_ff @(posedge ui_clk) begin
        if (cmd_push)
            cmdq_mem[cq_wr_ptr_reg[CQ_AW-1:0]] <= {cmd, addr[3 +: MEM_AW]};
        if (wdf_push)
            wdfq_mem[wq_wr_ptr_reg[WQ_AW-1:0]] <= {wr_data_mask, wr_data};
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            cq_wr_ptr_reg <= '0;
            cq_rd_ptr_reg <= '0;
            wq_wr_ptr_reg <= '0;
            wq_rd_ptr_reg <= '0;
            err           <= 1'b0;
        end else begin
            if (cmd_push) cq_wr_ptr_reg <= cq_wr_ptr_reg + (CQ_AW+1)'(1);
            if (cmd_pop)  cq_rd_ptr_reg <= cq_rd_ptr_reg + (CQ_AW+1)'(1);
            if (wdf_push) wq_wr_ptr_reg <= wq_wr_ptr_reg + (WQ_AW+1)'(1);
            if (wdf_pop)  wq_rd_ptr_reg <= wq_rd_ptr_reg + (WQ_AW+1)'(1);
            if ((cmd_push && cmd != CMD_WR && cmd != CMD_RD) || (wr_data_en != wr_data_end))
                err <= 1'b1;
        end
    end

    logic [DATA_W-1:0] mem [2**MEM_AW];

    always_ff @(posedge ui_clk) begin
        if (exec_write) begin
            for (int b = 0; b < NB; b++) begin
                if (!wdf_mask[b])
                    mem[head_idx][b*8 +: 8] <= wdf_data[b*8 +: 8];
            end
        end
    end

    // Stage 0 is the BRAM output register; data stages only load on a valid beat
    // so rd_data holds its last value between pulses.
    logic [RD_LATENCY-1:0] pipe_valid_reg;
    logic [DATA_W-1:0]     pipe_data_reg [RD_LATENCY];

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            pipe_valid_reg <= '0;
            for (int s = 0; s < RD_LATENCY; s++)
                pipe_data_reg[s] <= '0;
        end else begin
            pipe_valid_reg[0] <= exec_read;
            if (exec_read)
                pipe_data_reg[0] <= mem[head_idx];
            for (int s = 1; s < RD_LATENCY; s++) begin
                pipe_valid_reg[s] <= pipe_valid_reg[s-1];
                if (pipe_valid_reg[s-1])
                    pipe_data_reg[s] <= pipe_data_reg[s-1];
            end
        end
    end

    assign rd_data             = pipe_data_reg[RD_LATENCY-1];
    assign rd_data_valid       = pipe_valid_reg[RD_LATENCY-1];
    assign rd_data_end         = pipe_valid_reg[RD_LATENCY-1];
    assign init_calib_complete = calib_reg;

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Directed bench for ddr3_app_responder: calibration, read latency, ordering,
// masking, protocol errors, refresh backpressure and mid-run reset.
module tb_ddr3_app_responder;
    localparam int LAT = 4;
    localparam logic [2:0] WR = 3'b000;
    localparam logic [2:0] RD = 3'b001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         srst = 1'b1;
    logic [2:0]   cmd = 3'b000;
    logic         cmd_en = 1'b0;
    logic [28:0]  addr = '0;
    logic         cmd_ready;
    logic [255:0] wr_data = '0;
    logic         wr_data_en = 1'b0;
    logic         wr_data_end = 1'b0;
    logic [31:0]  wr_data_mask = '0;
    logic         wr_data_rdy;
    logic [255:0] rd_data;
    logic         rd_data_valid, rd_data_end, init_calib_complete, err;

    logic         r_srst = 1'b1;
    logic [2:0]   r_cmd = 3'b001;
    logic         r_cmd_en = 1'b1;
    logic [28:0]  r_addr = '0;
    logic [255:0] r_wr_data = '0;
    logic         r_wr_en = 1'b0;
    logic         r_wr_end = 1'b0;
    logic [31:0]  r_mask = '0;
    logic         r_cmd_ready, r_wr_rdy, r_rd_valid, r_rd_end, r_calib, r_err;
    logic [255:0] r_rd_data;

    ddr3_app_responder u_dut (
        .ui_clk(clk), .ui_clk_sync_rst(srst), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
        .cmd_ready(cmd_ready), .wr_data(wr_data), .wr_data_en(wr_data_en),
        .wr_data_end(wr_data_end), .wr_data_mask(wr_data_mask), .wr_data_rdy(wr_data_rdy),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_end(rd_data_end),
        .init_calib_complete(init_calib_complete), .err(err)
    );

    ddr3_app_responder #(.REF_PERIOD(32), .REF_CYCLES(8)) u_dut_ref (
        .ui_clk(clk), .ui_clk_sync_rst(r_srst), .cmd(r_cmd), .cmd_en(r_cmd_en), .addr(r_addr),
        .cmd_ready(r_cmd_ready), .wr_data(r_wr_data), .wr_data_en(r_wr_en),
        .wr_data_end(r_wr_end), .wr_data_mask(r_mask), .wr_data_rdy(r_wr_rdy),
        .rd_data(r_rd_data), .rd_data_valid(r_rd_valid), .rd_data_end(r_rd_end),
        .init_calib_complete(r_calib), .err(r_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [255:0] rd_q_data[$];
    int           rd_q_cyc[$];

    always @(negedge clk) begin
        if (rd_data_valid) begin
            rd_q_data.push_back(rd_data);
            rd_q_cyc.push_back(cyc);
            check("rd_end", rd_data_end, 1'b1);
            $display("read beat cyc=%0d data=%0h", cyc, rd_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_cmd(input logic [2:0] c, input logic [28:0] a, output int hs);
        int n = 0;
        cmd = c; addr = a; cmd_en = 1'b1;
        while (!cmd_ready && n < 300) begin
            tick(1);
            n++;
        end
        if (n >= 300) check("cmd_timeout", 0, 1);
        hs = cyc;
        tick(1);
        cmd_en = 1'b0;
        $display("cmd %b addr=%0h accepted cyc=%0d", c, a, hs);
    endtask

    task automatic push_beat(input logic [255:0] d, input logic [31:0] m, input logic end_bit);
        int n = 0;
        wr_data = d; wr_data_mask = m; wr_data_en = 1'b1; wr_data_end = end_bit;
        while (!wr_data_rdy && n < 300) begin
            tick(1);
            n++;
        end
        if (n >= 300) check("beat_timeout", 0, 1);
        tick(1);
        wr_data_en = 1'b0; wr_data_end = 1'b0;
        $display("beat data=%0h mask=%0h accepted cyc=%0d", d, m, cyc);
    endtask

    task automatic wait_read(output logic [255:0] d, output int c);
        int n = 0;
        while (rd_q_data.size() == 0 && n < 100) begin
            tick(1);
            n++;
        end
        if (rd_q_data.size() == 0) begin
            check("rd_timeout", 0, 1);
            d = '0;
            c = 0;
        end else begin
            d = rd_q_data.pop_front();
            c = rd_q_cyc.pop_front();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, vc, lows, run;
        int hsr[4];
        int vcs[4];
        logic [255:0] d, nv, ev, dvals[4];

        for (int i = 0; i < 4; i++) dvals[i] = {8{32'h0C0D_0000 + 32'(i)}};

        tick(3);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_wr_rdy", wr_data_rdy, 1'b0);
        check("rst_valid", rd_data_valid, 1'b0);
        check("rst_end", rd_data_end, 1'b0);
        check("rst_calib", init_calib_complete, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rd_data", rd_data, 256'h0);

        srst = 1'b0; r_srst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick(1);
            check("calib", init_calib_complete, (k >= 64) ? 1'b1 : 1'b0);
            if (k == 63) check("cmd_ready_pre", cmd_ready, 1'b0);
            if (k == 64) begin
                check("cmd_ready_post", cmd_ready, 1'b1);
                check("wr_rdy_post", wr_data_rdy, 1'b1);
            end
        end

        // Refresh: cmd_ready of the short-period instance, cmd_en held high.
        check("ref_calib", r_calib, 1'b1);
        run = 0;
        for (int w = 0; w < 3; w++) begin
            lows = 0;
            for (int k = 0; k < 32; k++) begin
                if (!r_cmd_ready) begin
                    lows++;
                    run++;
                end else if (run != 0) begin
                    check("ref_run", run, 8);
                    run = 0;
                end
                tick(1);
            end
            check("ref_window", lows, 8);
            $display("refresh window %0d lows=%0d", w, lows);
        end
        check("ref_err", r_err, 1'b0);

        // Write then read, latency from handshake.
        push_beat({32{8'hA5}}, 32'h0, 1'b1);
        issue_cmd(WR, 29'h08, hs);
        tick(3);
        issue_cmd(RD, 29'h08, hs);
        wait_read(d, vc);
        check("rdA_data", d, {32{8'hA5}});
        check("rdA_lat", vc - hs, LAT + 1);

        // Write without data must hold back the following read.
        issue_cmd(WR, 29'h10, hs);
        issue_cmd(RD, 29'h10, hs);
        tick(15);
        check("no_overtake", rd_q_data.size(), 0);
        push_beat(256'h1234, 32'h0, 1'b1);
        wait_read(d, vc);
        check("rdB_data", d, 256'h1234);
        tick(10);
        check("rdB_one_pulse", rd_q_data.size(), 0);

        // Data leads commands: fill the write-data queue.
        for (int i = 0; i < 4; i++) begin
            push_beat(dvals[i], 32'h0, 1'b1);
            check("wdf_rdy", wr_data_rdy, (i < 3) ? 1'b1 : 1'b0);
        end
        wr_data = '1; wr_data_en = 1'b1; wr_data_end = 1'b1;
        tick(2);
        check("wdf_full_hold", wr_data_rdy, 1'b0);
        wr_data_en = 1'b0; wr_data_end = 1'b0;
        for (int i = 0; i < 4; i++) issue_cmd(WR, 29'(i * 8), hs);
        for (int i = 0; i < 4; i++) issue_cmd(RD, 29'(i * 8), hsr[i]);
        for (int i = 0; i < 4; i++) begin
            wait_read(d, vcs[i]);
            check("rdC_data", d, dvals[i]);
            check("rdC_b2b", vcs[i] - vcs[0], i);
        end

        // Masked write over all-ones; read via aliased address bits.
        nv = {8{32'h1357_9BDF}};
        ev = nv;
        ev[31:0] = 32'hFFFF_FFFF;
        push_beat({256{1'b1}}, 32'h0, 1'b1);
        issue_cmd(WR, 29'h20, hs);
        push_beat(nv, 32'h0000_000F, 1'b1);
        issue_cmd(WR, 29'h20, hs);
        tick(3);
        issue_cmd(RD, 29'h2023, hs);
        wait_read(d, vc);
        check("rdM_data", d, ev);

        // Illegal command code.
        check("err_pre_illegal", err, 1'b0);
        issue_cmd(3'b101, 29'h08, hs);
        tick(10);
        check("err_illegal", err, 1'b1);
        check("illegal_no_read", rd_q_data.size(), 0);
        issue_cmd(RD, 29'h08, hs);
        wait_read(d, vc);
        check("rd_after_illegal", d, dvals[1]);
        check("err_sticky", err, 1'b1);

        // Reset with two reads in flight.
        issue_cmd(RD, 29'h08, hs);
        issue_cmd(RD, 29'h10, hs);
        srst = 1'b1;
        tick(1);
        check("mid_rst_valid", rd_data_valid, 1'b0);
        check("mid_rst_rd_data", rd_data, 256'h0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_calib", init_calib_complete, 1'b0);
        tick(2);
        srst = 1'b0;
        tick(70);
        check("flush_no_valid", rd_q_data.size(), 0);
        check("recal", init_calib_complete, 1'b1);
        issue_cmd(RD, 29'h08, hs);
        wait_read(d, vc);
        check("keep_08", d, dvals[1]);
        issue_cmd(RD, 29'h18, hs);
        wait_read(d, vc);
        check("keep_18", d, dvals[3]);

        // wr_data_end mismatch: flagged but beat still written.
        check("err_pre_end", err, 1'b0);
        push_beat(256'hBEEF_0042, 32'h0, 1'b0);
        check("err_end", err, 1'b1);
        issue_cmd(WR, 29'h28, hs);
        tick(3);
        issue_cmd(RD, 29'h28, hs);
        wait_read(d, vc);
        check("end_beat_used", d, 256'hBEEF_0042);

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
